// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared decode table, DMA state encoding and address defaults for the CPU bus controller.
// Pure definitions: no latency, no flow control.
package cpu_bus_ctrl_pkg;

  localparam int CH_RAM  = 0;
  localparam int CH_PPU  = 1;
  localparam int CH_APU  = 2;
  localparam int CH_CART = 3;
  localparam int CH_EXT0 = 4;
  localparam int CH_EXT1 = 5;

  localparam logic [15:0] DMA_REG_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_DEF = 16'h2004;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] limit;
    logic [15:0] mask;
  } region_t;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_RD    = 3'd3,
    DMA_WR    = 3'd4
  } dma_state_e;

  // 0x4018-0x401F (disabled test registers) belong to no channel, so reads there are open bus.
  // Entries from CH_EXT0 up are only decoded when N_CH is large enough, and override the cart.
  function automatic region_t chan_region(input int ch);
    case (ch)
      CH_RAM:  return '{base: 16'h0000, limit: 16'h1FFF, mask: 16'h07FF};
      CH_PPU:  return '{base: 16'h2000, limit: 16'h3FFF, mask: 16'h2007};
      CH_APU:  return '{base: 16'h4000, limit: 16'h4017, mask: 16'hFFFF};
      CH_CART: return '{base: 16'h4020, limit: 16'hFFFF, mask: 16'hFFFF};
      CH_EXT0: return '{base: 16'h6000, limit: 16'h7FFF, mask: 16'hFFFF};
      CH_EXT1: return '{base: 16'h4020, limit: 16'h5FFF, mask: 16'hFFFF};
      default: return '{base: 16'hFFFF, limit: 16'h0000, mask: 16'hFFFF};
    endcase
  endfunction

  function automatic logic in_region(input region_t r, input logic [15:0] a);
    return (a >= r.base) && (a <= r.limit);
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_oam_dma_engine.sv
// OAM DMA engine: halts the CPU, optionally aligns, then copies DMA_LEN bytes page -> OAM_DATA.
// One bus access per cpu_ce; the engine only advances on cpu_ce and never stalls otherwise.
module oam_dma_engine
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          DMA_LEN  = 256,
  parameter logic [15:0] OAM_DATA = OAM_DATA_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_ce_i,
  input  logic              trig_i,
  input  logic [DATA_W-1:0] page_dat_i,
  input  logic [DATA_W-1:0] rd_dat_i,
  output logic              busy_o,
  output logic              acc_o,
  output logic [15:0]       addr_o,
  output logic              r_nw_o,
  output logic [DATA_W-1:0] wdata_o
);

  localparam int IDX_W = $clog2(DMA_LEN) + 1;

  dma_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        page_q, page_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              parity_q;
  logic [15:0]       idx_ext;

  assign idx_ext = 16'(idx_q);
  assign busy_o  = (state_q != DMA_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= DMA_IDLE;
      idx_q    <= '0;
      page_q   <= '0;
      buf_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      buf_q    <= buf_d;
      parity_q <= parity_q ^ cpu_ce_i;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    buf_d   = buf_q;
    acc_o   = 1'b0;
    addr_o  = {page_q, idx_ext[7:0]};
    r_nw_o  = 1'b1;
    wdata_o = buf_q;

    case (state_q)
      DMA_RD: acc_o = 1'b1;
      DMA_WR: begin
        acc_o  = 1'b1;
        addr_o = OAM_DATA;
        r_nw_o = 1'b0;
      end
      default: ;
    endcase

    if (cpu_ce_i) begin
      case (state_q)
        DMA_IDLE: if (trig_i) begin
          state_d = DMA_HALT;
          page_d  = page_dat_i[7:0];
          idx_d   = '0;
        end
        // An odd halt cycle costs one extra cycle so reads land on the same parity every time.
        DMA_HALT:  state_d = parity_q ? DMA_ALIGN : DMA_RD;
        DMA_ALIGN: state_d = DMA_RD;
        DMA_RD: begin
          buf_d   = rd_dat_i;
          state_d = DMA_WR;
        end
        DMA_WR: begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == IDX_W'(DMA_LEN - 1)) ? DMA_IDLE : DMA_RD;
        end
        default: state_d = DMA_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: address decode/mirroring, read mux into registered cpu_rdata, OAM DMA master.
// Read data lands one clk after the cpu_ce cycle; DMA halts the CPU through cpu_rdy_o.
module cpu_bus_ctrl
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter int          DATA_W   = 8,
  parameter int          DMA_LEN  = 256,
  parameter logic [15:0] DMA_REG  = DMA_REG_DEF,
  parameter logic [15:0] OAM_DATA = OAM_DATA_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_ce_i,
  input  logic [15:0]              cpu_addr_i,
  input  logic                     cpu_r_nw_i,
  input  logic [DATA_W-1:0]        cpu_wdata_i,
  output logic [DATA_W-1:0]        cpu_rdata_o,
  output logic                     cpu_rdy_o,
  output logic [15:0]              bus_addr_o,
  output logic                     bus_r_nw_o,
  output logic [DATA_W-1:0]        bus_wdata_o,
  output logic [N_CH-1:0]          bus_cs_o,
  input  logic [N_CH*DATA_W-1:0]   ch_rdata_i,
  output logic                     dma_busy_o
);

  logic              dma_busy, dma_acc, dma_r_nw;
  logic [15:0]       dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              cpu_reg_hit, trig;
  logic [15:0]       mst_addr, mask;
  logic              mst_r_nw, mst_en;
  logic [DATA_W-1:0] mst_wdata, sel_rdata;
  logic [N_CH-1:0]   sel;
  region_t           reg_i;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign cpu_reg_hit = !dma_busy && (cpu_addr_i == DMA_REG);
  assign trig        = cpu_ce_i && cpu_reg_hit && !cpu_r_nw_i;

  assign mst_addr  = dma_busy ? dma_addr  : cpu_addr_i;
  assign mst_r_nw  = dma_busy ? dma_r_nw  : cpu_r_nw_i;
  assign mst_wdata = dma_busy ? dma_wdata : cpu_wdata_i;
  // The DMA register itself is never forwarded to a channel, in either direction.
  assign mst_en    = dma_busy ? dma_acc   : !cpu_reg_hit;

  // Later table entries win, so extension channels override the cart range.
  always_comb begin
    sel   = '0;
    mask  = 16'hFFFF;
    reg_i = chan_region(0);
    for (int i = 0; i < N_CH; i++) begin
      reg_i = chan_region(i);
      if (in_region(reg_i, mst_addr)) begin
        sel    = '0;
        sel[i] = 1'b1;
        mask   = reg_i.mask;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel[i]) sel_rdata = sel_rdata | ch_rdata_i[i*DATA_W +: DATA_W];
    end
  end

  assign bus_addr_o  = mst_addr & mask;
  assign bus_r_nw_o  = mst_r_nw;
  assign bus_wdata_o = mst_wdata;
  assign bus_cs_o    = (cpu_ce_i && mst_en) ? sel : '0;
  assign cpu_rdy_o   = !dma_busy;
  assign dma_busy_o  = dma_busy;
  assign cpu_rdata_o = rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (cpu_ce_i && !dma_busy && cpu_r_nw_i && mst_en && (|sel)) rdata_d = sel_rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  oam_dma_engine #(
    .DATA_W   (DATA_W),
    .DMA_LEN  (DMA_LEN),
    .OAM_DATA (OAM_DATA)
  ) u_dma (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cpu_ce_i   (cpu_ce_i),
    .trig_i     (trig),
    .page_dat_i (cpu_wdata_i),
    .rd_dat_i   (sel_rdata),
    .busy_o     (dma_busy),
    .acc_o      (dma_acc),
    .addr_o     (dma_addr),
    .r_nw_o     (dma_r_nw),
    .wdata_o    (dma_wdata)
  );

endmodule
